// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared pipeline encodings, memory FSM states and M-register layout
package memory_stage_pkg;

    // result_src encodings
    localparam logic [2:0] RES_ALU = 3'd0;
    localparam logic [2:0] RES_MEM = 3'd1;
    localparam logic [2:0] RES_PC4 = 3'd2;
    localparam logic [2:0] RES_IMM = 3'd3;
    localparam logic [2:0] RES_CSR = 3'd4;

    // width_src encodings (RV32 funct3)
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_DONE
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        csr_we;
        logic [2:0]  result_src;
        logic [2:0]  width_src;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [31:0] csr_result;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
    } m_reg_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
    function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (width)
            W_H, W_HU: mis = addr_lo[0];
            W_W:       mis = (addr_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - store lane steering, byte enables and load lane extraction/extension
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  width,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        case (width[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                wdata = store_data;
                be    = 4'b1111;
            end
        endcase
    end

    // Pick the addressed lane of the read word, then sign- or zero-extend by width.
    always_comb begin
        lane_byte = load_word[7:0];
        case (addr_lo)
            2'd0: lane_byte = load_word[7:0];
            2'd1: lane_byte = load_word[15:8];
            2'd2: lane_byte = load_word[23:16];
            2'd3: lane_byte = load_word[31:24];
            default: lane_byte = load_word[7:0];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        case (width)
            W_B:     load_data = {{24{lane_byte[7]}}, lane_byte};
            W_BU:    load_data = {24'h0, lane_byte};
            W_H:     load_data = {{16{lane_half[15]}}, lane_half};
            W_HU:    load_data = {16'h0, lane_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32 M stage: pipeline register, data-memory handshake FSM, optional MEM_MISALIGN_CHECK_EN
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_e_i,
    input  logic        reg_write_e_i,
    input  logic        mem_write_e_i,
    input  logic        csr_we_e_i,
    input  logic [2:0]  result_src_e_i,
    input  logic [2:0]  width_src_e_i,
    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] write_data_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] imm_ext_e_i,
    input  logic [31:0] csr_result_e_i,
    input  logic [31:0] pc_e_i,
    input  logic [31:0] instr_e_i,
    input  logic [11:0] csr_addr_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic        stall_m_i,
    input  logic        flush_m_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    output logic        mem_busy_o,
    output logic [31:0] forward_data_m_o,
    output logic [31:0] load_data_m_o,
    output logic        valid_m_o,
    output logic        reg_write_m_o,
    output logic        csr_we_m_o,
    output logic [2:0]  result_src_m_o,
    output logic [4:0]  rd_m_o,
    output logic [11:0] csr_addr_m_o,
    output logic [31:0] alu_result_m_o,
    output logic [31:0] pc_plus4_m_o,
    output logic [31:0] imm_ext_m_o,
    output logic [31:0] csr_result_m_o,
    output logic [31:0] pc_m_o,
    output logic [31:0] instr_m_o,
    output logic        misalign_m_o
);

    m_reg_t      e_bus;
    m_reg_t      m;
    mem_state_t  state;
    logic [31:0] rdata_buf;
    logic [31:0] raw_word;
    logic        is_load;
    logic        pending;
    logic        misalign;
    logic        access_req;
    logic        ack_now;
    logic        advance;

    // Gather the E-stage fields into one bundle for the M register.
    always_comb begin
        e_bus            = '0;
        e_bus.valid      = valid_e_i;
        e_bus.reg_write  = reg_write_e_i;
        e_bus.mem_write  = mem_write_e_i;
        e_bus.csr_we     = csr_we_e_i;
        e_bus.result_src = result_src_e_i;
        e_bus.width_src  = width_src_e_i;
        e_bus.alu_result = alu_result_e_i;
        e_bus.write_data = write_data_e_i;
        e_bus.pc_plus4   = pc_plus4_e_i;
        e_bus.imm_ext    = imm_ext_e_i;
        e_bus.csr_result = csr_result_e_i;
        e_bus.pc         = pc_e_i;
        e_bus.instr      = instr_e_i;
        e_bus.csr_addr   = csr_addr_e_i;
        e_bus.rd         = rd_e_i;
    end

    assign is_load = (m.result_src == RES_MEM);
    assign pending = m.valid && (is_load || m.mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = pending && is_misaligned(m.width_src, m.alu_result[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign access_req = pending && !misalign;
    assign dmem_req_o = ((state == MEM_IDLE) && access_req) || (state == MEM_BUSY);
    assign ack_now    = dmem_req_o && dmem_ack_i;
    assign mem_busy_o = dmem_req_o && !dmem_ack_i;
    // The M register takes a new value (or bubble) this edge.
    assign advance    = !mem_busy_o && (flush_m_i || !stall_m_i);

    // M pipeline register: an outstanding access holds it even over a flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m <= '0;
        end else if (!mem_busy_o) begin
            if (flush_m_i) begin
                m <= '0;
            end else if (!stall_m_i) begin
                m <= e_bus;
            end
        end
    end

    // Handshake FSM; an ack in a cycle where the register also advances goes straight back
    // to IDLE so the next instruction's access is not mistaken for the completed one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= MEM_IDLE;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (access_req) begin
                        if (dmem_ack_i) begin
                            state <= advance ? MEM_IDLE : MEM_DONE;
                        end else begin
                            state <= MEM_BUSY;
                        end
                    end
                end
                MEM_BUSY: begin
                    if (dmem_ack_i) begin
                        state <= advance ? MEM_IDLE : MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    if (advance) begin
                        state <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    // Keep the returned load word for as long as the load sits stalled in M.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_buf <= '0;
        end else if (ack_now && is_load) begin
            rdata_buf <= dmem_rdata_i;
        end
    end

    assign raw_word = ack_now ? dmem_rdata_i : rdata_buf;

    load_store_align u_align (
        .addr_lo    (m.alu_result[1:0]),
        .width      (m.width_src),
        .store_data (m.write_data),
        .load_word  (raw_word),
        .wdata      (dmem_wdata_o),
        .be         (dmem_be_o),
        .load_data  (load_data_m_o)
    );

    // Forwarding value for the hazard unit.
    always_comb begin
        case (m.result_src)
            RES_ALU: forward_data_m_o = m.alu_result;
            RES_PC4: forward_data_m_o = m.pc_plus4;
            RES_IMM: forward_data_m_o = m.imm_ext;
            RES_CSR: forward_data_m_o = m.csr_result;
            default: forward_data_m_o = m.alu_result;
        endcase
    end

    assign dmem_we_o      = m.mem_write;
    assign dmem_addr_o    = {m.alu_result[31:2], 2'b00};
    assign misalign_m_o   = misalign;
    assign valid_m_o      = m.valid;
    assign reg_write_m_o  = m.reg_write && !misalign;
    assign csr_we_m_o     = m.csr_we && !misalign;
    assign result_src_m_o = m.result_src;
    assign rd_m_o         = m.rd;
    assign csr_addr_m_o   = m.csr_addr;
    assign alu_result_m_o = m.alu_result;
    assign pc_plus4_m_o   = m.pc_plus4;
    assign imm_ext_m_o    = m.imm_ext;
    assign csr_result_m_o = m.csr_result;
    assign pc_m_o         = m.pc;
    assign instr_m_o      = m.instr;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL be fixed, with RV32 data at 32 bits.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- valid_e_i, reg_write_e_i, mem_write_e_i, csr_we_e_i  in  1 each  E-stage qualifiers
- result_src_e_i, width_src_e_i  in  3 each  result select; access width (funct3 encoding)
- alu_result_e_i, write_data_e_i, pc_plus4_e_i, imm_ext_e_i, csr_result_e_i, pc_e_i, instr_e_i  in  32 each  E-stage data
- csr_addr_e_i  in  12  CSR address
- rd_e_i  in  5  destination register
- stall_m_i, flush_m_i  in  1 each  hazard-unit controls
- dmem_ack_i  in  1  data memory completion
- dmem_rdata_i  in  32  read word
- dmem_req_o, dmem_we_o  out  1 each  request; write enable
- dmem_addr_o, dmem_wdata_o  out  32 each  word address (bits [1:0]=0); lane-aligned store data
- dmem_be_o  out  4  byte enables
- mem_busy_o  out  1  stall request to the hazard unit
- forward_data_m_o, load_data_m_o  out  32 each  M-stage forwarding value; extended load data
- valid_m_o, reg_write_m_o, csr_we_m_o  out  1 each  registered qualifiers
- result_src_m_o  out  3;  rd_m_o  out  5;  csr_addr_m_o  out  12
- alu_result_m_o, pc_plus4_m_o, imm_ext_m_o, csr_result_m_o, pc_m_o, instr_m_o  out  32 each
- misalign_m_o  out  1  misaligned access flag

Function
REQ-003 The M pipeline register SHALL capture all *_e_i fields on a clock edge; priority: reset > mem_busy_o hold > flush_m_i (clear to zero) > stall_m_i (hold) > load.
REQ-004 An access SHALL be pending when valid_m_o=1 and either result_src_m_o=RES_MEM (load) or the registered mem_write is set (store).
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE; IDLE -> BUSY on a pending access without dmem_ack_i; IDLE/BUSY -> DONE on dmem_ack_i; DONE -> IDLE when the M register loads or flushes.
REQ-006 dmem_req_o SHALL be 1 in IDLE-with-pending-access and in BUSY; ack in the same cycle as request SHALL be legal; a request SHALL never be reissued from DONE.
REQ-007 mem_busy_o SHALL equal dmem_req_o AND NOT dmem_ack_i.
REQ-008 On ack of a load, dmem_rdata_i SHALL be captured into a 32-bit buffer; load_data_m_o SHALL bypass the extended dmem_rdata_i in the ack cycle and come from the buffer in DONE.
REQ-009 Loads SHALL select the lane by alu_result[1:0] and sign- or zero-extend per width_src (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 Stores SHALL replicate write_data across lanes; dmem_be_o SHALL be 0001<<a[1:0] for B, 0011<<a[1] *2 for H, and 1111 for W.
REQ-011 forward_data_m_o SHALL select by result_src: RES_ALU -> alu_result, RES_PC4 -> pc_plus4, RES_IMM -> imm_ext, RES_CSR -> csr_result, others -> alu_result.

Reset
REQ-012 On reset_i, all registered outputs, the buffer and misalign_m_o SHALL be 0 and the FSM SHALL enter IDLE; reset during BUSY SHALL drop dmem_req_o immediately.

Configuration
REQ-013 With MEM_MISALIGN_CHECK_EN defined, a pending H access with a[0]=1 or W access with a[1:0]!=0 SHALL suppress dmem_req_o, assert misalign_m_o, and force reg_write_m_o and csr_we_m_o to 0; without it, misalign_m_o SHALL be tied 0 and the access SHALL proceed with the computed enables.

Structure
REQ-014 RES_* and width encodings and the FSM state enum SHALL reside in the shared pipeline package.
REQ-015 Lane steering, byte-enable generation and load extension SHALL be one combinational sub-module, load_store_align.

Verification
REQ-016 LW at 0x100 with ack two cycles after request -> mem_busy_o=1 for 2 cycles, load_data_m_o = rdata 0xDEADBEEF.
REQ-017 LB at 0x103 with rdata 0x80FF_FFFF, same-cycle ack -> load_data_m_o=0xFFFFFF80, mem_busy_o never 1.
REQ-018 SH of 0x1234 at 0x102 -> dmem_be_o=1100, dmem_wdata_o=0x12341234, dmem_we_o=1.
REQ-019 flush_m_i asserted in BUSY -> register held until ack, then cleared on the next load.
REQ-020 reset_i asserted in BUSY -> dmem_req_o=0 asynchronously, FSM IDLE; with MEM_MISALIGN_CHECK_EN, LW at 0x101 -> misalign_m_o=1, dmem_req_o=0.
